bist_controller: RTL and testbench
==================================

// Module: bist_controller
// PURPOSE
//  Sequences one BIST session around the 8-bit MISR and the pattern LFSR.
//  Resets the MISR, selects LFSR patterns onto the CUT, runs N_PATTERNS compaction cycles,
//  freezes the MISR with bist_end, waits for its registered signature, then compares it to GOLDEN_SIG.
//  Sits between the top-level test interface (start/abort, pass/fail) and the LFSR/MISR/CUT datapath.
// PARAMETERS
//  N_PATTERNS   255      compaction cycles per session; legal range 1..2**CNT_W-1
//  CNT_W        16       pattern counter width
//  FLUSH_CYCLES 2        cycles after freeze before the signature is sampled; must be >=1 (MISR hf lags h by 1)
//  GOLDEN_SIG   8'h00    expected fault-free signature {h0..h7}
// PORTS
//  CLK         in   1      clock, all logic on rising edge
//  RST         in   1      reset, synchronous, active-low
//  start       in   1      level; sampled in IDLE and DONE only, launches a session
//  abort       in   1      level; returns to IDLE from any state
//  misr_sig    in   8      MISR hf output
//  misr_rst    out  1      to MISR RST (active-high, synchronous)
//  bist_end    out  1      to MISR bist_end; 0 = compact, 1 = hold
//  lfsr_en     out  1      LFSR advance enable
//  mode_sel    out  1      1 = CUT inputs from LFSR, 0 = functional inputs
//  pattern_cnt out  CNT_W  patterns applied in the current session
//  busy        out  1      1 in INIT, RUN, FLUSH, COMPARE
//  done        out  1      1 in DONE
//  pass        out  1      signature == GOLDEN_SIG; valid while done=1
//  fail        out  1      signature != GOLDEN_SIG; valid while done=1
// BEHAVIOUR
//  States: IDLE, INIT, RUN, FLUSH, COMPARE, DONE; registered state, Moore outputs.
//  RST=0 at an edge: state=IDLE, pattern_cnt=0, flush counter=0, pass=fail=0.
//  Output values after reset: misr_rst=0, bist_end=1, lfsr_en=0, mode_sel=0, busy=0, done=0.
//  IDLE: bist_end=1. start=1 -> INIT.
//  INIT (1 cycle): misr_rst=1, mode_sel=1, pattern_cnt<=0, pass<=0, fail<=0 -> RUN.
//  RUN: bist_end=0, lfsr_en=1, mode_sel=1, pattern_cnt increments each cycle.
//    When pattern_cnt==N_PATTERNS-1: -> FLUSH, pattern_cnt ends at N_PATTERNS.
//    Exactly N_PATTERNS cycles have bist_end=0.
//  FLUSH: bist_end=1, lfsr_en=0, mode_sel=1; stays FLUSH_CYCLES cycles, then -> COMPARE.
//  COMPARE (1 cycle): pass<=(misr_sig==GOLDEN_SIG), fail<=~that -> DONE.
//  DONE: bist_end=1, mode_sel=0; pass/fail/pattern_cnt hold. start=1 -> INIT (rerun).
//  pass and fail are never both 1, and are both 0 outside DONE.
//  Latency: start sampled at edge E -> done=1 after edge E+N_PATTERNS+FLUSH_CYCLES+3.
//  abort=1 in any state -> IDLE at next edge, pass=fail=0, pattern_cnt=0.
//    No misr_rst is issued on abort; the next session re-initialises the MISR in INIT.
//  Precedence: RST > abort > start. start is ignored in INIT/RUN/FLUSH/COMPARE.
//  RST mid-session: identical to power-up reset; the session is lost and no done is produced.
//  N_PATTERNS=1: RUN lasts exactly one cycle.
//  pattern_cnt never wraps within legal parameter range.
// TESTING
//  1 Reset: RST=0 for 2 cycles mid-RUN -> IDLE; bist_end=1; misr_rst=busy=done=pass=fail=0; pattern_cnt=0.
//  2 Nominal, N_PATTERNS=4, FLUSH_CYCLES=2, start at edge 0 ->
//    misr_rst=1 cycle 1; bist_end=0 cycles 2-5; done=1 from cycle 9.
//    Also checked: pattern_cnt=4; pass=1 with GOLDEN_SIG from the reference MISR model driven by the LFSR stream.
//  3 Mismatch: same run with GOLDEN_SIG = model^8'h01 -> done=1, fail=1, pass=0.
//  4 Abort: abort=1 at cycle 3 (in RUN) -> IDLE at cycle 4; bist_end=1, pattern_cnt=0, done=0; MISR holds.
//  5 Rerun: start=1 while in DONE -> INIT next cycle, pass/fail cleared; second run gives identical pass.
//  6 Ignored start: start held high through the whole session -> single INIT pulse; after DONE an immediate rerun occurs.

Source files
------------

// File: rtl/bist_controller.sv
// bist_controller: sequences one BIST session around the pattern LFSR and the
// 8-bit MISR. A session resets the MISR, runs N_PATTERNS compaction cycles with
// the CUT fed from the LFSR, freezes the MISR, waits out the signature pipeline
// and compares the registered signature against GOLDEN_SIG.
//
// Outputs are registered decodes of the state held during the cycle that just
// ended, so every datapath control appears one edge after the FSM enters the
// corresponding state. The pass/fail capture is aligned to the same lag: it
// samples misr_sig on the edge that raises done. This keeps done, pass and fail
// rising together, and leaves FLUSH_CYCLES >= 1 enough to cover the MISR's
// one-cycle hf lag.
module bist_controller #(
    parameter int         N_PATTERNS   = 255,
    parameter int         CNT_W        = 16,
    parameter int         FLUSH_CYCLES = 2,
    parameter logic [7:0] GOLDEN_SIG   = 8'h00
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       misr_sig,
    output logic             misr_rst,
    output logic             bist_end,
    output logic             lfsr_en,
    output logic             mode_sel,
    output logic [CNT_W-1:0] pattern_cnt,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail
);

    localparam int               FL_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PATTERNS - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_FLUSH,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;        // compaction cycles issued by the FSM
    logic [FL_W-1:0]  flush_cnt;  // cycles spent in FLUSH
    logic             cmp_q;      // last cycle was COMPARE: signature is due now

    // Session FSM, pattern/flush counters and registered Moore outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            flush_cnt   <= '0;
            cmp_q       <= 1'b0;
            misr_rst    <= 1'b0;
            bist_end    <= 1'b1;
            lfsr_en     <= 1'b0;
            mode_sel    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            pattern_cnt <= '0;
        end else if (abort) begin
            // Drop straight to idle outputs; the MISR is left frozen and is
            // re-initialised by the next session's INIT.
            state       <= S_IDLE;
            cnt         <= '0;
            flush_cnt   <= '0;
            cmp_q       <= 1'b0;
            misr_rst    <= 1'b0;
            bist_end    <= 1'b1;
            lfsr_en     <= 1'b0;
            mode_sel    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            pattern_cnt <= '0;
        end else begin
            misr_rst    <= (state == S_INIT);
            bist_end    <= (state != S_RUN);
            lfsr_en     <= (state == S_RUN);
            mode_sel    <= (state == S_INIT) || (state == S_RUN) || (state == S_FLUSH);
            busy        <= (state == S_INIT) || (state == S_RUN) ||
                           (state == S_FLUSH) || (state == S_COMPARE);
            done        <= (state == S_DONE);
            pattern_cnt <= cnt;
            cmp_q       <= (state == S_COMPARE);

            if (cmp_q) begin
                pass <= (misr_sig == GOLDEN_SIG);
                fail <= (misr_sig != GOLDEN_SIG);
            end else if (state == S_INIT) begin
                pass <= 1'b0;
                fail <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_INIT;
                        cnt   <= '0;
                    end
                end
                S_INIT: begin
                    cnt   <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST)
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (flush_cnt == FL_LAST) begin
                        flush_cnt <= '0;
                        state     <= S_COMPARE;
                    end else begin
                        flush_cnt <= flush_cnt + FL_W'(1);
                    end
                end
                S_COMPARE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: three controllers share one stimulus stream, each with its
// own LFSR -> CUT (identity) -> MISR datapath.
//   inst 0: N=4, F=2, golden = reference signature   (expects pass)
//   inst 1: N=4, F=2, golden = reference ^ 8'h01     (expects fail)
//   inst 2: N=1, F=1, golden = reference signature   (single-pattern boundary)
// Directed table vectors, two hand-written sequences, then random traffic
// checked against a phase-count model of a session.
module tb_bist_controller;

    typedef struct packed {
        logic        misr_rst;
        logic        bist_end;
        logic        lfsr_en;
        logic        mode_sel;
        logic        busy;
        logic        done;
        logic        pass;
        logic        fail;
        logic [15:0] pc;
    } out_t;

    typedef struct packed {
        logic rst_n;
        logic start;
        logic abort;
        out_t exp;
    } vec_t;

    localparam logic [7:0] SEED = 8'h01;

    function automatic logic [7:0] lfsr_nx(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] misr_nx(input logic [7:0] hh, input logic [7:0] d);
        return {hh[6:0], hh[7] ^ hh[5] ^ hh[4] ^ hh[3]} ^ d;
    endfunction

    // Signature after n patterns of the seeded LFSR stream.
    function automatic logic [7:0] ref_sig(input int n);
        logic [7:0] s = 8'h00;
        logic [7:0] l = SEED;
        for (int k = 0; k < n; k++) begin
            s = misr_nx(s, l);
            l = lfsr_nx(l);
        end
        return s;
    endfunction

    localparam logic [7:0] SIG4 = ref_sig(4);
    localparam logic [7:0] SIG1 = ref_sig(1);

    logic       CLK, RST, start, abort;
    logic [7:0] func_in;
    logic       misr_rst_w[3], bist_end_w[3], lfsr_en_w[3], mode_sel_w[3];
    logic       busy_w[3], done_w[3], pass_w[3], fail_w[3];
    logic [15:0] pc_w[3];
    logic [7:0] lf[3], h[3], hf[3];

    int checks = 0;
    int failures = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    bist_controller #(.N_PATTERNS(4), .CNT_W(16), .FLUSH_CYCLES(2), .GOLDEN_SIG(SIG4)) u_a (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .misr_sig(hf[0]),
        .misr_rst(misr_rst_w[0]), .bist_end(bist_end_w[0]), .lfsr_en(lfsr_en_w[0]),
        .mode_sel(mode_sel_w[0]), .pattern_cnt(pc_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]));

    bist_controller #(.N_PATTERNS(4), .CNT_W(16), .FLUSH_CYCLES(2), .GOLDEN_SIG(SIG4 ^ 8'h01)) u_b (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .misr_sig(hf[1]),
        .misr_rst(misr_rst_w[1]), .bist_end(bist_end_w[1]), .lfsr_en(lfsr_en_w[1]),
        .mode_sel(mode_sel_w[1]), .pattern_cnt(pc_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]));

    bist_controller #(.N_PATTERNS(1), .CNT_W(16), .FLUSH_CYCLES(1), .GOLDEN_SIG(SIG1)) u_c (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .misr_sig(hf[2]),
        .misr_rst(misr_rst_w[2]), .bist_end(bist_end_w[2]), .lfsr_en(lfsr_en_w[2]),
        .mode_sel(mode_sel_w[2]), .pattern_cnt(pc_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .pass(pass_w[2]), .fail(fail_w[2]));

    // Datapath per instance: LFSR reseeds with the MISR reset, CUT is identity.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (!RST || misr_rst_w[i]) begin
                h[i]  <= 8'h00;
                lf[i] <= SEED;
            end else begin
                if (!bist_end_w[i]) h[i] <= misr_nx(h[i], mode_sel_w[i] ? lf[i] : func_in);
                if (lfsr_en_w[i]) lf[i] <= lfsr_nx(lf[i]);
            end
            hf[i] <= RST ? h[i] : 8'h00;
        end
    end

    function automatic out_t mk(input logic mr, be, le, ms, bs, dn, ps, fl, input int pc);
        out_t o;
        o.misr_rst = mr; o.bist_end = be; o.lfsr_en = le; o.mode_sel = ms;
        o.busy = bs; o.done = dn; o.pass = ps; o.fail = fl; o.pc = 16'(pc);
        return o;
    endfunction

    function automatic out_t got_out(input int i);
        return mk(misr_rst_w[i], bist_end_w[i], lfsr_en_w[i], mode_sel_w[i],
                  busy_w[i], done_w[i], pass_w[i], fail_w[i], int'(pc_w[i]));
    endfunction

    // Outputs seen t edges after a start was accepted (t >= 1), from the
    // session timeline: 1 reset cycle, n compaction cycles, f flush cycles,
    // 1 compare cycle, then done.
    function automatic out_t phase_out(input int t, input int n, input int f, input logic res);
        if (t == 1)               return mk(1, 1, 0, 1, 1, 0, 0, 0, 0);
        else if (t <= n + 1)      return mk(0, 0, 1, 1, 1, 0, 0, 0, t - 2);
        else if (t <= n + f + 1)  return mk(0, 1, 0, 1, 1, 0, 0, 0, n);
        else if (t == n + f + 2)  return mk(0, 1, 0, 0, 1, 0, 0, 0, n);
        else                      return mk(0, 1, 0, 0, 0, 1, res, !res, n);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic a, input out_t e);
        vec_t v;
        v.rst_n = r; v.start = s; v.abort = a; v.exp = e;
        tbl.push_back(v);
    endtask

    // Nominal N=4/F=2 timeline, edges 1..9 after start is accepted.
    task automatic add_run();
        add(1, 0, 0, mk(1, 1, 0, 1, 1, 0, 0, 0, 0));
        add(1, 0, 0, mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
        add(1, 0, 0, mk(0, 0, 1, 1, 1, 0, 0, 0, 1));
        add(1, 0, 0, mk(0, 0, 1, 1, 1, 0, 0, 0, 2));
        add(1, 0, 0, mk(0, 0, 1, 1, 1, 0, 0, 0, 3));
        add(1, 0, 0, mk(0, 1, 0, 1, 1, 0, 0, 0, 4));
        add(1, 0, 0, mk(0, 1, 0, 1, 1, 0, 0, 0, 4));
        add(1, 0, 0, mk(0, 1, 0, 0, 1, 0, 0, 0, 4));
        add(1, 0, 0, mk(0, 1, 0, 0, 0, 1, 1, 0, 4));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t idl, dn, e;
        int   nmr, nbe, ncbe;
        int   mt[3];
        out_t me[3];
        int   pn[3] = '{4, 4, 1};
        int   pf[3] = '{2, 2, 1};
        logic pr[3] = '{1'b1, 1'b0, 1'b1};
        logic r, s, a;

        RST = 1'b0; start = 1'b0; abort = 1'b0; func_in = 8'h00;
        idl = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
        dn  = mk(0, 1, 0, 0, 0, 1, 1, 0, 4);

        // reset, start, reset mid-RUN, full session, rerun, abort, full session
        add(0, 0, 0, idl);
        add(0, 0, 0, idl);
        add(1, 1, 0, idl);
        add(1, 0, 0, mk(1, 1, 0, 1, 1, 0, 0, 0, 0));
        add(1, 0, 0, mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
        add(1, 0, 0, mk(0, 0, 1, 1, 1, 0, 0, 0, 1));
        add(0, 0, 0, idl);
        add(0, 0, 0, idl);
        add(1, 1, 0, idl);
        add_run();
        add(1, 0, 0, dn);
        add(1, 1, 0, dn);
        add(1, 0, 0, mk(1, 1, 0, 1, 1, 0, 0, 0, 0));
        add(1, 0, 0, mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
        add(1, 0, 0, mk(0, 0, 1, 1, 1, 0, 0, 0, 1));
        add(1, 0, 1, idl);
        add(1, 0, 0, idl);
        add(1, 1, 0, idl);
        add_run();
        add(1, 0, 0, dn);

        foreach (tbl[k]) begin
            RST = tbl[k].rst_n; start = tbl[k].start; abort = tbl[k].abort;
            @(posedge CLK); #1;
            e = tbl[k].exp;
            chk($sformatf("vec%0d_a", k), 32'(got_out(0)), 32'(e));
            chk($sformatf("vec%0d_b_done_pass_fail", k),
                32'({done_w[1], pass_w[1], fail_w[1]}), 32'({e.done, e.fail, e.pass}));
        end

        // start held high: one INIT per session, immediate rerun after done
        abort = 1'b1; start = 1'b0;
        @(posedge CLK); #1;
        abort = 1'b0; start = 1'b1;
        nmr = 0; nbe = 0;
        for (int j = 0; j < 10; j++) begin
            @(posedge CLK); #1;
            if (misr_rst_w[0]) nmr++;
            if (!bist_end_w[0]) nbe++;
        end
        chk("held_start_init_pulses", 32'(nmr), 32'd1);
        chk("held_start_compact_cycles", 32'(nbe), 32'd4);
        chk("held_start_done_pass", 32'({done_w[0], pass_w[0], fail_w[0]}), 32'b110);
        @(posedge CLK); #1;
        chk("held_start_rerun_init", 32'({misr_rst_w[0], done_w[0], pass_w[0]}), 32'b100);

        // single-pattern session on the N=1 instance
        start = 1'b0; abort = 1'b1;
        @(posedge CLK); #1;
        abort = 1'b0; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        ncbe = 0;
        for (int j = 0; j < 7; j++) begin
            @(posedge CLK); #1;
            if (!bist_end_w[2]) ncbe++;
        end
        chk("n1_compact_cycles", 32'(ncbe), 32'd1);
        chk("n1_done_pass_cnt", 32'({done_w[2], pass_w[2], fail_w[2], pc_w[2]}),
            32'({3'b110, 16'd1}));

        // random start/abort/reset traffic against the phase model
        for (int i = 0; i < 3; i++) begin mt[i] = -1; me[i] = idl; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = (cyc < 2) ? 1'b0 : ($urandom_range(199) != 0);
            a = ($urandom_range(63) == 0);
            s = ($urandom_range(3) == 0);
            RST = r; abort = a; start = s; func_in = 8'($urandom);
            for (int i = 0; i < 3; i++) begin
                if (!r || a) begin
                    mt[i] = -1;
                    me[i] = idl;
                end else begin
                    if (mt[i] >= 0) me[i] = phase_out(mt[i] + 1, pn[i], pf[i], pr[i]);
                    if (s && (mt[i] < 0 || mt[i] >= pn[i] + pf[i] + 2)) mt[i] = 0;
                    else if (mt[i] >= 0 && mt[i] < 1000) mt[i]++;
                end
            end
            @(posedge CLK); #1;
            for (int i = 0; i < 3; i++)
                chk($sformatf("rand_c%0d_inst%0d", cyc, i), 32'(got_out(i)), 32'(me[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
